// File: rtl/stopwatch_tick_ctrl.sv
// stopwatch_tick_ctrl: debounced run/clear keys drive an IDLE/RUN/PAUSE FSM and a tick prescaler.
// Latency: a clean key press changes running/clear DEBOUNCE_CYCLES+4 rising edges after the raw key falls.
// Backpressure: none; tick and clear are one-cycle enables the downstream counter must take immediately.
//
// Ports:
//   CLOCK_50  in  system clock, everything on the rising edge
//   rst       in  synchronous reset, active-high, overrides every event
//   key_run_n in  raw run/pause pushbutton, active-low, asynchronous to CLOCK_50
//   key_clr_n in  raw clear pushbutton, active-low, asynchronous to CLOCK_50
//   tick      out one-cycle enable, once every DIV cycles while running
//   clear     out one-cycle pulse telling the downstream counter to load zero
//   running   out high while the FSM is in RUN

module stopwatch_tick_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key_run_n,
  input  logic key_clr_n,
  output logic tick,
  output logic clear,
  output logic running
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = $clog2(DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit 0 is the run key, bit 1 the clear key.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      stable_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  logic run_ev;
  logic clr_ev;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick_nxt;
  logic          clear_nxt;

  // Synchronizer, debouncer and press-edge detector for both keys.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      stable   <= 2'b11;
      stable_d <= 2'b11;
      press    <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= {key_clr_n, key_run_n};
      sync2    <= sync1;
      stable_d <= stable;
      // Only the 1->0 (press) transition of the accepted level is an event.
      press    <= stable_d & ~stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // The new level has held long enough: accept it.
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign run_ev = press[0];
  assign clr_ev = press[1];

  // State, prescaler and output pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      tick  <= 1'b0;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      tick  <= tick_nxt;
      clear <= clear_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tick_nxt  = 1'b0;
    clear_nxt = 1'b0;
    if (clr_ev) begin
      // Clear outranks a simultaneous run event and suppresses a due tick.
      state_nxt = IDLE;
      presc_nxt = '0;
      clear_nxt = 1'b1;
    end else begin
      // A run event in the wrap cycle still lets that tick through.
      tick_nxt = (state == RUN) && (presc == PRESC_LAST);
      unique case (state)
        IDLE: begin
          presc_nxt = '0;
          if (run_ev) state_nxt = RUN;
        end
        RUN: begin
          presc_nxt = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
          if (run_ev) state_nxt = PAUSE;
        end
        PAUSE: begin
          // Prescaler holds so a resume continues the partial period.
          if (run_ev) state_nxt = RUN;
        end
        default: begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end
      endcase
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
module tb_stopwatch_tick_ctrl;

  logic CLOCK_50 = 1'b0;
  logic rst = 1'b1;
  logic key_run_n = 1'b1;
  logic key_clr_n = 1'b1;
  logic tick;
  logic clear;
  logic running;

  stopwatch_tick_ctrl #(
    .CLK_HZ(10),
    .TICK_HZ(1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .key_run_n(key_run_n),
    .key_clr_n(key_clr_n),
    .tick(tick),
    .clear(clear),
    .running(running)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int tick_q[$];
  int clr_q[$];
  int rise_q[$];
  int fall_q[$];
  logic prev_run = 1'b0;

  // One clock: sample 1 ns after the rising edge and log output events by edge number.
  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (tick === 1'b1) tick_q.push_back(cyc);
    if (clear === 1'b1) clr_q.push_back(cyc);
    if (tick === 1'b1 && clear === 1'b1) overlap++;
    if (running === 1'b1 && prev_run !== 1'b1) rise_q.push_back(cyc);
    if (running === 1'b0 && prev_run === 1'b1) fall_q.push_back(cyc);
    prev_run = running;
  endtask

  task automatic cycles(input int n);
    repeat (n) clk1();
  endtask

  task automatic flush();
    tick_q.delete();
    clr_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int q1(input int q[$]);
    return (q.size() > 1) ? q[1] : -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b want 0", clear); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
    rst = 1'b0;
    flush();
    cycles(50);
    total++; if (tick_q.size() != 0) begin bad++; $display("FAIL idle_ticks: got %0d want 0", tick_q.size()); end
    total++; if (clr_q.size() != 0) begin bad++; $display("FAIL idle_clears: got %0d want 0", clr_q.size()); end
    total++; if (rise_q.size() != 0 || running !== 1'b0) begin bad++; $display("FAIL idle_running: got rises=%0d running=%b want 0", rise_q.size(), running); end
  endtask

  task automatic test_run_tick();
    int f;
    int n;
    flush();
    f = cyc;
    key_run_n = 1'b0;
    cycles(12);
    key_run_n = 1'b1;
    cycles(60);
    total++; if (q0(rise_q) != f + 8) begin bad++; $display("FAIL run_latency: got edge %0d want %0d", q0(rise_q), f + 8); end
    total++; if (q0(tick_q) != f + 18) begin bad++; $display("FAIL first_tick: got edge %0d want %0d", q0(tick_q), f + 18); end
    total++; if (q1(tick_q) != f + 28) begin bad++; $display("FAIL second_tick: got edge %0d want %0d", q1(tick_q), f + 28); end
    n = 0;
    foreach (tick_q[i]) if (tick_q[i] <= f + 8 + 50) n++;
    total++; if (n != 5) begin bad++; $display("FAIL ticks_in_50: got %0d want 5", n); end
    total++; if (fall_q.size() != 0) begin bad++; $display("FAIL release_no_event: got falls=%0d want 0", fall_q.size()); end
  endtask

  task automatic test_bounce();
    int f;
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    flush();
    repeat (3) begin
      key_run_n = 1'b0;
      cycles(3);
      key_run_n = 1'b1;
      cycles(2);
    end
    cycles(20);
    total++; if (rise_q.size() != 0 || running !== 1'b0) begin bad++; $display("FAIL bounce_ignored: got rises=%0d running=%b want 0", rise_q.size(), running); end
    f = cyc;
    key_run_n = 1'b0;
    cycles(5);
    key_run_n = 1'b1;
    cycles(12);
    total++; if (q0(rise_q) != f + 8) begin bad++; $display("FAIL clean_5_press: got edge %0d want %0d", q0(rise_q), f + 8); end
  endtask

  task automatic test_pause_resume();
    int t;
    int n;
    flush();
    n = 0;
    while (n < 30 && tick_q.size() == 0) begin
      clk1();
      n++;
    end
    if (tick_q.size() == 0) begin
      total++; bad++;
      $display("FAIL pause_wait_tick: got no tick within 30 cycles want one");
      return;
    end
    t = cyc;
    flush();
    cycles(7);
    key_run_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    cycles(24);
    key_run_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    cycles(20);
    total++; if (q0(fall_q) != t + 15) begin bad++; $display("FAIL pause_edge: got edge %0d want %0d", q0(fall_q), t + 15); end
    total++; if (q0(rise_q) != t + 45) begin bad++; $display("FAIL resume_edge: got edge %0d want %0d", q0(rise_q), t + 45); end
    total++; if (q0(tick_q) != t + 10) begin bad++; $display("FAIL pre_pause_tick: got edge %0d want %0d", q0(tick_q), t + 10); end
    total++; if (q1(tick_q) != t + 50) begin bad++; $display("FAIL resume_tick: got edge %0d want %0d", q1(tick_q), t + 50); end
    total++; if (tick_q.size() != 3) begin bad++; $display("FAIL pause_tick_count: got %0d want 3", tick_q.size()); end
  endtask

  task automatic test_clear_running();
    int u;
    int f;
    int n;
    flush();
    n = 0;
    while (n < 30 && tick_q.size() == 0) begin
      clk1();
      n++;
    end
    if (tick_q.size() == 0) begin
      total++; bad++;
      $display("FAIL clear_wait_tick: got no tick within 30 cycles want one");
      return;
    end
    u = cyc;
    flush();
    cycles(9);
    key_clr_n = 1'b0;
    cycles(6);
    key_clr_n = 1'b1;
    cycles(20);
    total++; if (clr_q.size() != 1 || q0(clr_q) != u + 17) begin bad++; $display("FAIL clear_pulse: got count=%0d edge=%0d want 1 at %0d", clr_q.size(), q0(clr_q), u + 17); end
    total++; if (q0(fall_q) != u + 17 || running !== 1'b0) begin bad++; $display("FAIL clear_stops: got fall=%0d running=%b want %0d 0", q0(fall_q), running, u + 17); end
    total++; if (tick_q.size() != 1 || q0(tick_q) != u + 10) begin bad++; $display("FAIL no_tick_after_clear: got count=%0d first=%0d want 1 at %0d", tick_q.size(), q0(tick_q), u + 10); end
    flush();
    f = cyc;
    key_run_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    cycles(24);
    total++; if (q0(rise_q) != f + 8) begin bad++; $display("FAIL restart_latency: got edge %0d want %0d", q0(rise_q), f + 8); end
    total++; if (q0(tick_q) != f + 18) begin bad++; $display("FAIL restart_first_tick: got edge %0d want %0d", q0(tick_q), f + 18); end
  endtask

  task automatic test_back_to_back();
    int f;
    // Running since 30 cycles ago with ticks every 10, so the clear lands on a due tick.
    flush();
    f = cyc;
    key_run_n = 1'b0;
    key_clr_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    cycles(15);
    total++; if (clr_q.size() != 1 || q0(clr_q) != f + 8) begin bad++; $display("FAIL both_clear_pulse: got count=%0d edge=%0d want 1 at %0d", clr_q.size(), q0(clr_q), f + 8); end
    total++; if (q0(fall_q) != f + 8 || rise_q.size() != 0 || running !== 1'b0) begin bad++; $display("FAIL both_to_idle: got fall=%0d rises=%0d running=%b want %0d 0 0", q0(fall_q), rise_q.size(), running, f + 8); end
    total++; if (tick_q.size() != 0) begin bad++; $display("FAIL clear_beats_tick: got %0d ticks want 0", tick_q.size()); end
    flush();
    f = cyc;
    key_run_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    cycles(11);
    total++; if (q0(rise_q) != f + 8) begin bad++; $display("FAIL prereset_run: got edge %0d want %0d", q0(rise_q), f + 8); end
    rst = 1'b1;
    clk1();
    total++; if (tick !== 1'b0 || clear !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL midrun_reset: got tick=%b clear=%b running=%b want 0 0 0", tick, clear, running); end
    rst = 1'b0;
    flush();
    f = cyc;
    key_run_n = 1'b0;
    cycles(6);
    key_run_n = 1'b1;
    cycles(24);
    total++; if (q0(rise_q) != f + 8) begin bad++; $display("FAIL postreset_latency: got edge %0d want %0d", q0(rise_q), f + 8); end
    total++; if (q0(tick_q) != f + 18) begin bad++; $display("FAIL postreset_tick: got edge %0d want %0d", q0(tick_q), f + 18); end
    total++; if (overlap != 0) begin bad++; $display("FAIL tick_clear_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_bounce();
    test_pause_resume();
    test_clear_running();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns want finish");
    $fatal(1);
  end

endmodule
